// File: rtl/ftq_entry_queue.sv
// Fetch Target Queue: buffers predicted fetch blocks from the BPU, issues them
// in order to the ICache, and keeps each entry resident until the backend
// commits it. Three wrap-bit pointers track enqueue, fetch issue and commit.
module ftq_entry_queue #(
    parameter int DEPTH = 16,
    parameter int PTR_W = 4,
    parameter int PC_W  = 32,
    parameter int AF_TH = 14
) (
    input  logic             Clk,
    input  logic             Rest,
    input  logic             FTQStop,
    input  logic             FTQFlash,
    input  logic             EnqValid,
    input  logic [PC_W-1:0]  EnqStartPc,
    input  logic [PC_W-1:0]  EnqNextPc,
    input  logic             EnqTaken,
    output logic             EnqReady,
    output logic             FetchValid,
    input  logic             FetchReady,
    output logic [PC_W-1:0]  FetchPc,
    output logic [PC_W-1:0]  FetchNextPc,
    output logic             FetchTaken,
    output logic [PTR_W-1:0] FetchIdx,
    input  logic             CommitValid,
    output logic             FTQReq,
    output logic [PTR_W:0]   Count
);

    localparam logic [PTR_W:0] PTR_ZERO = {(PTR_W+1){1'b0}};
    localparam logic [PTR_W:0] PTR_ONE  = {{PTR_W{1'b0}}, 1'b1};
    localparam logic [PTR_W:0] AF_LIMIT = (PTR_W+1)'(AF_TH);

    // Entry storage; intentionally not reset or cleared on flush.
    logic [PC_W-1:0] startPcMem_r [DEPTH];
    logic [PC_W-1:0] nextPcMem_r  [DEPTH];
    logic [DEPTH-1:0] takenMem_r;

    logic [PTR_W:0] enqPtr_r;
    logic [PTR_W:0] fchPtr_r;
    logic [PTR_W:0] cmtPtr_r;
    logic [PTR_W:0] count_r;
    logic           ftqReq_r;

    logic [PTR_W:0] enqPtrNext_s;
    logic [PTR_W:0] fchPtrNext_s;
    logic [PTR_W:0] cmtPtrNext_s;
    logic [PTR_W:0] countNext_s;
    logic           full_s;
    logic           enqFire_s;
    logic           fetchFire_s;
    logic           cmtFire_s;

    // Handshake decode: full blocks enqueue even when a commit frees a slot this cycle.
    always_comb begin
        full_s      = (enqPtr_r[PTR_W-1:0] == cmtPtr_r[PTR_W-1:0]) &&
                      (enqPtr_r[PTR_W] != cmtPtr_r[PTR_W]);
        EnqReady    = ~full_s & ~FTQStop & ~FTQFlash;
        FetchValid  = (fchPtr_r != enqPtr_r) & ~FTQStop & ~FTQFlash;
        enqFire_s   = EnqValid & EnqReady;
        fetchFire_s = FetchValid & FetchReady;
        cmtFire_s   = CommitValid & (cmtPtr_r != fchPtr_r);
    end

    // Next-pointer selection; flush overrides every same-cycle pointer move.
    always_comb begin
        enqPtrNext_s = enqPtr_r;
        fchPtrNext_s = fchPtr_r;
        cmtPtrNext_s = cmtPtr_r;
        if (FTQFlash) begin
            enqPtrNext_s = PTR_ZERO;
            fchPtrNext_s = PTR_ZERO;
            cmtPtrNext_s = PTR_ZERO;
        end else begin
            if (enqFire_s) begin
                enqPtrNext_s = enqPtr_r + PTR_ONE;
            end else begin
                enqPtrNext_s = enqPtr_r;
            end
            if (fetchFire_s) begin
                fchPtrNext_s = fchPtr_r + PTR_ONE;
            end else begin
                fchPtrNext_s = fchPtr_r;
            end
            if (cmtFire_s) begin
                cmtPtrNext_s = cmtPtr_r + PTR_ONE;
            end else begin
                cmtPtrNext_s = cmtPtr_r;
            end
        end
        countNext_s = enqPtrNext_s - cmtPtrNext_s;
    end

    // Pointer, occupancy and almost-full registers; async reset drops all entries at once.
    always_ff @(posedge Clk or negedge Rest) begin
        if (!Rest) begin
            enqPtr_r <= PTR_ZERO;
            fchPtr_r <= PTR_ZERO;
            cmtPtr_r <= PTR_ZERO;
            count_r  <= PTR_ZERO;
            ftqReq_r <= 1'b0;
        end else begin
            enqPtr_r <= enqPtrNext_s;
            fchPtr_r <= fchPtrNext_s;
            cmtPtr_r <= cmtPtrNext_s;
            count_r  <= countNext_s;
            ftqReq_r <= (countNext_s >= AF_LIMIT);
        end
    end

    // Entry write on enqueue fire; no enqueue-to-fetch bypass, so data is seen next cycle.
    always_ff @(posedge Clk) begin
        if (enqFire_s) begin
            startPcMem_r[enqPtr_r[PTR_W-1:0]] <= EnqStartPc;
            nextPcMem_r[enqPtr_r[PTR_W-1:0]]  <= EnqNextPc;
            takenMem_r[enqPtr_r[PTR_W-1:0]]   <= EnqTaken;
        end
    end

    // Offered entry is read straight from storage at the fetch pointer.
    always_comb begin
        FetchIdx    = fchPtr_r[PTR_W-1:0];
        FetchPc     = startPcMem_r[fchPtr_r[PTR_W-1:0]];
        FetchNextPc = nextPcMem_r[fchPtr_r[PTR_W-1:0]];
        FetchTaken  = takenMem_r[fchPtr_r[PTR_W-1:0]];
        Count       = count_r;
        FTQReq      = ftqReq_r;
    end

endmodule

// File: tb/tb_ftq_entry_queue.sv
// Directed self-checking bench for ftq_entry_queue.
module tb_ftq_entry_queue;

    logic        Clk;
    logic        Rest;
    logic        FTQStop;
    logic        FTQFlash;
    logic        EnqValid;
    logic [31:0] EnqStartPc;
    logic [31:0] EnqNextPc;
    logic        EnqTaken;
    logic        EnqReady;
    logic        FetchValid;
    logic        FetchReady;
    logic [31:0] FetchPc;
    logic [31:0] FetchNextPc;
    logic        FetchTaken;
    logic [3:0]  FetchIdx;
    logic        CommitValid;
    logic        FTQReq;
    logic [4:0]  Count;

    int checkCnt;
    int errorCnt;

    ftq_entry_queue #(.DEPTH(16), .PTR_W(4), .PC_W(32), .AF_TH(14)) dut (
        .Clk(Clk), .Rest(Rest), .FTQStop(FTQStop), .FTQFlash(FTQFlash),
        .EnqValid(EnqValid), .EnqStartPc(EnqStartPc), .EnqNextPc(EnqNextPc),
        .EnqTaken(EnqTaken), .EnqReady(EnqReady), .FetchValid(FetchValid),
        .FetchReady(FetchReady), .FetchPc(FetchPc), .FetchNextPc(FetchNextPc),
        .FetchTaken(FetchTaken), .FetchIdx(FetchIdx), .CommitValid(CommitValid),
        .FTQReq(FTQReq), .Count(Count)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checkCnt++;
        if (obs !== expv) begin
            errorCnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic setEnq(input logic v, input logic [31:0] pc);
        EnqValid   = v;
        EnqStartPc = pc;
        EnqNextPc  = pc + 32'h100;
        EnqTaken   = pc[4];
    endtask

    initial begin
        logic [31:0] pc;
        int enqd;
        int fchd;
        int cmtd;
        int cyc;
        int expCount;
        logic expFv;
        logic expEr;
        logic fr;
        logic cv;

        checkCnt = 0;
        errorCnt = 0;
        Rest = 1'b0;
        FTQStop = 1'b0;
        FTQFlash = 1'b0;
        FetchReady = 1'b0;
        CommitValid = 1'b0;
        setEnq(1'b0, 32'h0);
        #12;
        checkVal("rst_count", 32'(Count), 32'd0);
        checkVal("rst_fv", 32'(FetchValid), 32'd0);
        checkVal("rst_er", 32'(EnqReady), 32'd1);
        checkVal("rst_req", 32'(FTQReq), 32'd0);
        Rest = 1'b1;
        tick();

        // Test 1: back-to-back enqueue with fetch ready
        FetchReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pc = 32'h1000 + 32'(i) * 32'h10;
            setEnq(1'b1, pc);
            tick();
            #1;
            checkVal("t1_fv", 32'(FetchValid), 32'd1);
            checkVal("t1_pc", FetchPc, pc);
            checkVal("t1_npc", FetchNextPc, pc + 32'h100);
            checkVal("t1_tk", 32'(FetchTaken), 32'(pc[4]));
            checkVal("t1_idx", 32'(FetchIdx), 32'(i));
        end
        setEnq(1'b0, 32'h0);
        tick();
        checkVal("t1_drain_fv", 32'(FetchValid), 32'd0);
        checkVal("t1_count", 32'(Count), 32'd3);
        FetchReady = 1'b0;
        CommitValid = 1'b1;
        tick(); tick(); tick();
        checkVal("t1_cmt_count", 32'(Count), 32'd0);
        tick();
        checkVal("t1_cmt_ignored", 32'(Count), 32'd0);
        CommitValid = 1'b0;

        // Test 2: fill to 16 without fetch/commit
        for (int i = 0; i < 16; i++) begin
            setEnq(1'b1, 32'h2000 + 32'(i) * 32'h10);
            #1;
            checkVal("t2_er", 32'(EnqReady), 32'd1);
            tick();
            checkVal("t2_count", 32'(Count), 32'(i + 1));
            checkVal("t2_req", 32'(FTQReq), 32'((i + 1) >= 14));
        end
        setEnq(1'b1, 32'h2F00);
        #1;
        checkVal("t2_full_er", 32'(EnqReady), 32'd0);
        tick();
        checkVal("t2_17th_count", 32'(Count), 32'd16);
        checkVal("t2_idx", 32'(FetchIdx), 32'd3);
        checkVal("t2_pc", FetchPc, 32'h2000);

        // Test 3: commit at full does not open enqueue in the same cycle
        setEnq(1'b0, 32'h0);
        FetchReady = 1'b1;
        tick();
        FetchReady = 1'b0;
        checkVal("t3_fetched_idx", 32'(FetchIdx), 32'd4);
        setEnq(1'b1, 32'h3000);
        CommitValid = 1'b1;
        #1;
        checkVal("t3_er_full", 32'(EnqReady), 32'd0);
        tick();
        checkVal("t3_count15", 32'(Count), 32'd15);
        CommitValid = 1'b0;
        #1;
        checkVal("t3_er_open", 32'(EnqReady), 32'd1);
        tick();
        checkVal("t3_count16", 32'(Count), 32'd16);
        checkVal("t3_req", 32'(FTQReq), 32'd1);
        setEnq(1'b0, 32'h0);

        // Test 4: flush
        FTQFlash = 1'b1;
        tick();
        FTQFlash = 1'b0;
        #1;
        checkVal("t4_fl0_count", 32'(Count), 32'd0);
        checkVal("t4_fl0_req", 32'(FTQReq), 32'd0);
        for (int i = 0; i < 5; i++) begin
            setEnq(1'b1, 32'h4000 + 32'(i) * 32'h10);
            tick();
        end
        setEnq(1'b0, 32'h0);
        FetchReady = 1'b1;
        tick(); tick(); tick();
        FetchReady = 1'b0;
        #1;
        checkVal("t4_idx3", 32'(FetchIdx), 32'd3);
        checkVal("t4_pc3", FetchPc, 32'h4030);
        checkVal("t4_count5", 32'(Count), 32'd5);
        FTQFlash = 1'b1;
        setEnq(1'b1, 32'h4100);
        FetchReady = 1'b1;
        CommitValid = 1'b1;
        #1;
        checkVal("t4_fl_er", 32'(EnqReady), 32'd0);
        checkVal("t4_fl_fv", 32'(FetchValid), 32'd0);
        tick();
        FTQFlash = 1'b0;
        setEnq(1'b0, 32'h0);
        FetchReady = 1'b0;
        CommitValid = 1'b0;
        #1;
        checkVal("t4_count", 32'(Count), 32'd0);
        checkVal("t4_fv", 32'(FetchValid), 32'd0);
        checkVal("t4_req", 32'(FTQReq), 32'd0);
        setEnq(1'b1, 32'h5000);
        tick();
        setEnq(1'b0, 32'h0);
        #1;
        checkVal("t4_new_fv", 32'(FetchValid), 32'd1);
        checkVal("t4_new_idx", 32'(FetchIdx), 32'd0);
        checkVal("t4_new_pc", FetchPc, 32'h5000);

        // Test 5: stop holds enqueue/fetch, commit still retires
        FetchReady = 1'b1;
        setEnq(1'b1, 32'h5010);
        tick();
        FetchReady = 1'b0;
        setEnq(1'b1, 32'h5020);
        tick();
        setEnq(1'b1, 32'h5030);
        tick();
        FTQStop = 1'b1;
        CommitValid = 1'b1;
        FetchReady = 1'b1;
        setEnq(1'b1, 32'h5F00);
        #1;
        checkVal("t5_fv", 32'(FetchValid), 32'd0);
        checkVal("t5_er", 32'(EnqReady), 32'd0);
        tick();
        checkVal("t5_cmt", 32'(Count), 32'd3);
        tick();
        checkVal("t5_cmt_ign", 32'(Count), 32'd3);
        FTQStop = 1'b0;
        CommitValid = 1'b0;
        FetchReady = 1'b0;
        setEnq(1'b0, 32'h0);
        #1;
        checkVal("t5_resume_fv", 32'(FetchValid), 32'd1);
        checkVal("t5_resume_idx", 32'(FetchIdx), 32'd1);
        checkVal("t5_resume_pc", FetchPc, 32'h5010);

        // Test 6: stream 40 blocks with interleaved fetch and commit
        FTQFlash = 1'b1;
        tick();
        FTQFlash = 1'b0;
        enqd = 0; fchd = 0; cmtd = 0; cyc = 0;
        while (cmtd < 40 && cyc < 400) begin
            fr = ((cyc % 3) != 0);
            cv = ((cyc % 2) == 1);
            setEnq(enqd < 40, 32'h6000 + 32'(enqd) * 32'h10);
            FetchReady = fr;
            CommitValid = cv;
            #1;
            expCount = enqd - cmtd;
            expFv = (fchd < enqd);
            expEr = (expCount < 16);
            checkVal("t6_count", 32'(Count), 32'(expCount));
            checkVal("t6_req", 32'(FTQReq), 32'(expCount >= 14));
            checkVal("t6_fv", 32'(FetchValid), 32'(expFv));
            checkVal("t6_er", 32'(EnqReady), 32'(expEr));
            if (expFv) begin
                checkVal("t6_pc", FetchPc, 32'h6000 + 32'(fchd) * 32'h10);
                checkVal("t6_idx", 32'(FetchIdx), 32'(fchd % 16));
            end
            if ((enqd < 40) && expEr) enqd++;
            if (cv && (cmtd < fchd)) cmtd++;
            if (expFv && fr) fchd++;
            tick();
            cyc++;
        end
        checkVal("t6_all_committed", 32'(cmtd), 32'd40);
        setEnq(1'b0, 32'h0);
        FetchReady = 1'b0;
        CommitValid = 1'b1;
        tick();
        CommitValid = 1'b0;
        checkVal("t6_extra_cmt", 32'(Count), 32'd0);

        // Asynchronous reset mid-operation
        setEnq(1'b1, 32'h7000);
        tick();
        setEnq(1'b1, 32'h7010);
        tick();
        setEnq(1'b0, 32'h0);
        checkVal("rst2_pre_count", 32'(Count), 32'd2);
        #1;
        Rest = 1'b0;
        #1;
        checkVal("rst2_count", 32'(Count), 32'd0);
        checkVal("rst2_fv", 32'(FetchValid), 32'd0);
        checkVal("rst2_er", 32'(EnqReady), 32'd1);
        tick();
        Rest = 1'b1;

        $display("Result: errors=%0d of %0d checks", errorCnt, checkCnt);
        $finish;
    end

endmodule
